// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide, with sign fix-up in a final FIX cycle and MTHI/MTLO moves.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [4:0]       cnt;
  logic [WIDTH-1:0] acc_hi;   // partial product high half / running remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] opnd;     // multiplicand or divisor magnitude
  logic             is_div;
  logic             neg_q;    // negate product or quotient
  logic             neg_r;    // negate remainder
  logic             dz;

  // Operand magnitudes: signed ops strip the sign here and restore it in FIX.
  logic             rs_neg, rt_neg, rt_zero;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  assign rs_neg  = op[0] & rs_data[WIDTH-1];
  assign rt_neg  = op[0] & rt_data[WIDTH-1];
  assign rs_mag  = rs_neg ? (~rs_data + 1'b1) : rs_data;
  assign rt_mag  = rt_neg ? (~rt_data + 1'b1) : rt_data;
  assign rt_zero = (rt_data == '0);

  // One shift-add multiply step.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

  // One restoring divide step; the remainder always fits back into WIDTH bits.
  logic [WIDTH:0] div_shift, div_rem;
  logic           div_ge;
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign div_rem   = div_ge ? (div_shift - {1'b0, opnd}) : div_shift;

  // Sign correction applied in FIX.
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? (~prod + 1'b1) : prod;
  assign quo_fix  = neg_q ? (~acc_lo + 1'b1) : acc_lo;
  assign rem_fix  = neg_r ? (~acc_hi + 1'b1) : acc_hi;

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (!op[1])      state_nxt = MUL;
          else if (rt_zero) state_nxt = FIX;
          else             state_nxt = DIV;
        end
      end
      MUL, DIV: begin
        if (cnt == '1) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt    <= '0;
            opnd   <= rt_mag;
            acc_lo <= rs_mag;
            is_div <= op[1];
            neg_q  <= rs_neg ^ rt_neg;
            neg_r  <= rs_neg;
            dz     <= op[1] & rt_zero;
            // Divide-by-zero carries the raw dividend straight to HI.
            acc_hi <= (op[1] & rt_zero) ? rs_data : '0;
          end else begin
            if (mthi) hi <= rs_data;
            if (mtlo) lo <= rs_data;
          end
        end
        MUL: begin
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          cnt              <= cnt + 5'd1;
        end
        DIV: begin
          acc_hi <= div_rem[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          cnt    <= cnt + 5'd1;
        end
        FIX: begin
          done <= 1'b1;
          if (dz) begin
            lo          <= '1;
            hi          <= acc_hi;
            div_by_zero <= 1'b1;
          end else if (is_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, signed/unsigned
// results, divide-by-zero, ignored starts/moves, register moves and reset abort.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        mthi, mtlo;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] OP_MULTU = 2'b00, OP_MULT = 2'b01,
                         OP_DIVU  = 2'b10, OP_DIV  = 2'b11;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Launches an operation and returns at the negedge where done is seen.
  // Cycle n is the clock period after the n-th edge following the start edge.
  // inj > 0 drives start+mthi (rs=AAAA5555) during cycle inj and samples hi at inj+2.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj, output int lat, output int busy_n,
                        output logic dz_seen, output logic [31:0] hi_mid);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; busy_n = 0; dz_seen = 1'b0; hi_mid = 'x;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == inj) begin
        start = 1'b1; mthi = 1'b1; op = OP_MULTU; rs_data = 32'hAAAA5555; rt_data = 32'd2;
      end else if (n == inj + 1) begin
        start = 1'b0; mthi = 1'b0;
      end
      if (n == inj + 2) hi_mid = hi;
      if (busy) busy_n++;
      if (done) begin
        lat = n; dz_seen = div_by_zero;
        break;
      end
    end
    total++;
    if (lat == 0) begin
      bad++;
      $display("FAIL op_timeout: got=no done expected=done within 60 cycles");
    end
  endtask

  // Confirms done stays low for the next k cycles.
  task automatic expect_quiet(input string name, input int k);
    int pulses;
    pulses = 0;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      if (done || div_by_zero) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL %s: got=%0d extra pulses expected=0", name, pulses);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    mthi = 1'b0; mtlo = 1'b0;
    repeat (3) @(negedge clk);
    chk32("reset_hi", hi, 32'h0);
    chk32("reset_lo", lo, 32'h0);
    chk32("reset_flags", {29'd0, busy, done, div_by_zero}, 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic test_mult();
    int lat, bn; logic dzs; logic [31:0] hm;
    run_op(OP_MULT, 32'hFFFFFFFD, 32'h00000007, 0, lat, bn, dzs, hm);
    chk32("mult_hi", hi, 32'hFFFFFFFF);
    chk32("mult_lo", lo, 32'hFFFFFFEB);
    chk32("mult_latency", lat, 34);
    chk32("mult_busy_cycles", bn, 33);
    chk32("mult_dz", {31'd0, dzs}, 32'd0);
    @(negedge clk);
    chk32("mult_done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  task automatic test_div();
    int lat, bn; logic dzs; logic [31:0] hm;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002, 0, lat, bn, dzs, hm);
    chk32("div_lo", lo, 32'hFFFFFFFD);
    chk32("div_hi", hi, 32'hFFFFFFFF);
    chk32("div_latency", lat, 34);
    run_op(OP_DIVU, 32'd100, 32'd7, 0, lat, bn, dzs, hm);
    chk32("divu_lo", lo, 32'd14);
    chk32("divu_hi", hi, 32'd2);
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, lat, bn, dzs, hm);
    chk32("div_ovf_lo", lo, 32'h80000000);
    chk32("div_ovf_hi", hi, 32'h0);
    run_op(OP_DIV, 32'd20, 32'hFFFFFFFA, 0, lat, bn, dzs, hm);
    chk32("div_posneg_lo", lo, 32'hFFFFFFFD);
    chk32("div_posneg_hi", hi, 32'd2);
  endtask

  task automatic test_div_by_zero();
    int lat, bn; logic dzs; logic [31:0] hm;
    run_op(OP_DIVU, 32'h12345678, 32'h0, 0, lat, bn, dzs, hm);
    chk32("dz_lo", lo, 32'hFFFFFFFF);
    chk32("dz_hi", hi, 32'h12345678);
    chk32("dz_latency", lat, 2);
    chk32("dz_flag", {31'd0, dzs}, 32'd1);
    expect_quiet("dz_single_pulse", 3);
  endtask

  task automatic test_ignored_while_busy();
    int lat, bn; logic dzs; logic [31:0] hm;
    // hi currently holds 0x12345678 from the previous divide-by-zero
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 10, lat, bn, dzs, hm);
    chk32("busy_hi_undisturbed", hm, 32'h12345678);
    chk32("busy_hi", hi, 32'hFFFFFFFE);
    chk32("busy_lo", lo, 32'h00000001);
    chk32("busy_latency", lat, 34);
    expect_quiet("busy_no_queued_op", 40);
  endtask

  task automatic test_moves();
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; rs_data = 32'hDEADBEEF;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk32("move_hi", hi, 32'hDEADBEEF);
    chk32("move_lo", lo, 32'hDEADBEEF);
    chk32("move_no_done", {31'd0, done}, 32'd0);
    rs_data = 32'h0000C0DE; mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0;
    chk32("mtlo_only_lo", lo, 32'h0000C0DE);
    chk32("mtlo_only_hi", hi, 32'hDEADBEEF);
  endtask

  task automatic test_start_beats_move();
    int lat, bn; logic dzs; logic [31:0] hm;
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1;
    run_op(OP_MULTU, 32'd6, 32'd7, 0, lat, bn, dzs, hm);
    mthi = 1'b0; mtlo = 1'b0;
    chk32("start_wins_lo", lo, 32'd42);
    chk32("start_wins_hi", hi, 32'd0);
  endtask

  task automatic test_reset_abort();
    int lat, bn; logic dzs; logic [31:0] hm;
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; rs_data = 32'd1000; rt_data = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk32("abort_hi", hi, 32'h0);
    chk32("abort_lo", lo, 32'h0);
    chk32("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_quiet("abort_no_done", 40);
    run_op(OP_MULTU, 32'd3, 32'd5, 0, lat, bn, dzs, hm);
    chk32("post_reset_lo", lo, 32'd15);
    chk32("post_reset_hi", hi, 32'd0);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_by_zero();
    test_ignored_while_busy();
    test_moves();
    test_start_beats_move();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand and HI/LO width; only the value 32 is supported.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, meaning launch of an operation using op, rs_data and rt_data.
REQ-005 SHALL have port op, input, 2, meaning 00=MULTU, 01=MULT, 10=DIVU, 11=DIV.
REQ-006 SHALL have port rs_data, input, 32, meaning register-file read port 1 (multiplicand/dividend, or the MTHI/MTLO source).
REQ-007 SHALL have port rt_data, input, 32, meaning register-file read port 2 (multiplier/divisor).
REQ-008 SHALL have port mthi, input, 1, meaning load HI from rs_data.
REQ-009 SHALL have port mtlo, input, 1, meaning load LO from rs_data.
REQ-010 SHALL have port busy, output, 1, meaning an operation is in progress.
REQ-011 SHALL have port done, output, 1, meaning a one-cycle pulse marking that HI/LO hold a new result.
REQ-012 SHALL have port div_by_zero, output, 1, meaning a pulse coincident with done for a divide with rt_data=0.
REQ-013 SHALL have port hi, output, 32, meaning the registered HI value, read by MFHI.
REQ-014 SHALL have port lo, output, 32, meaning the registered LO value, read by MFLO.

Function
REQ-015 SHALL use FSM states IDLE, MUL, DIV, FIX; busy=1 exactly when state is not IDLE.
REQ-016 In IDLE, a start at a rising edge SHALL capture operands and op.
  - The captured values are magnitudes for signed ops and raw values for unsigned ops.
  - Transition to MUL (op[1]=0) or DIV (op[1]=1).
REQ-017 MUL SHALL perform 32 shift-add iterations; DIV SHALL perform 32 restoring shift-subtract iterations, one per cycle, using a 5-bit iteration counter.
REQ-018 After the 32nd iteration the FSM SHALL enter FIX for one cycle, then return to IDLE.
  - FIX applies the sign correction and writes hi/lo.
  - The result is visible, with done=1, in the cycle after the FIX edge.
  - Latency from the start edge to done high: 34 cycles; busy is high for 33 cycles.
REQ-019 MULT/MULTU SHALL produce a 64-bit product, with {hi,lo} = product.
  - Signed: the product is negated when rs_data[31]^rt_data[31].
REQ-020 DIV/DIVU SHALL write lo=quotient and hi=remainder.
  - Signed: the quotient is negative when the operand signs differ, and the remainder takes the sign of the dividend.
REQ-021 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0 (no trap).
REQ-022 Divide with rt_data=0 SHALL skip iteration.
  - IDLE goes to FIX directly, setting lo=0xFFFFFFFF and hi=rs_data (raw).
  - done and div_by_zero pulse 2 cycles after the start edge.
REQ-023 start, mthi and mtlo while busy=1 SHALL be ignored, with no queuing.
REQ-024 In IDLE without start, mthi/mtlo SHALL write rs_data into hi/lo at the edge; both asserted SHALL write both, and no done pulse is produced.
REQ-025 A simultaneous start and mthi/mtlo in IDLE SHALL let start win; the moves are ignored.
REQ-026 hi/lo SHALL hold their values at all times other than REQ-018, REQ-022 and REQ-024.
  - In particular, hi/lo are not disturbed during an operation.
REQ-027 done and div_by_zero SHALL be high for exactly one cycle per completed operation.

Reset
REQ-028 rst_n=0 SHALL asynchronously force: state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0.
REQ-029 Reset mid-operation SHALL abort it; no done pulse follows deassertion.
REQ-030 The first start SHALL be honoured on the first rising edge after rst_n deasserts.

Verification
REQ-031 The bench SHALL cover MULT with rs=0xFFFFFFFD (-3) and rt=0x00000007.
  - Response: hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - done exactly 34 cycles after the start edge, and busy high 33 cycles.
REQ-032 The bench SHALL cover DIV with rs=0xFFFFFFF9 (-7) and rt=0x00000002.
  - Response: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - DIVU of 100 by 7 gives lo=14, hi=2.
REQ-033 The bench SHALL cover DIVU with rs=0x12345678 and rt=0.
  - Response: lo=0xFFFFFFFF, hi=0x12345678.
  - done and div_by_zero pulse together, 2 cycles after the start edge.
REQ-034 The bench SHALL cover a start, plus mthi with rs=0xAAAA5555, issued mid-MULTU of 0xFFFFFFFF by 0xFFFFFFFF.
  - Response: ignored, and hi=0xFFFFFFFE, lo=0x00000001 at done.
REQ-035 The bench SHALL cover mthi=mtlo=1 with rs=0xDEADBEEF in IDLE.
  - Response: hi=lo=0xDEADBEEF next cycle, with no done.
REQ-036 The bench SHALL cover rst_n pulled low at cycle 10 of a DIV.
  - Response: hi=lo=0 and busy=0 immediately, with no done afterwards.
  - A subsequent MULTU of 3 by 5 gives lo=15.
